serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial adder controller. It sequences a single 1-bit full-adder datapath, instantiated internally (sum = a^b^cin, carry = majority), over WIDTH clock cycles to add two WIDTH-bit operands LSB-first. The result is returned through a start/busy/done handshake. It sits wherever a small-area multi-bit add is needed and latency of WIDTH+1 cycles is acceptable.

Parameters:
WIDTH, 8, operand/result width in bits; legal range >= 1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse/level; sampled only in IDLE
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
cin  input  1  carry-in; captured on accepted start
busy  output  1  high while an addition is in progress (RUN)
done  output  1  one-cycle pulse: sum/cout valid and just updated
sum  output  WIDTH  result register; holds last result until next completion
cout  output  1  carry-out of last completed addition

Behaviour:
- One clock; reset is asynchronous and active-high: rst high immediately forces state=IDLE, busy=0, done=0, sum=0, cout=0, and clears internal shift registers, carry flop and bit counter.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: load a into shift reg SA, b into SB, cin into carry flop, bit counter=0; go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - busy=1.
  - On each edge, the full adder computes s = SA[0]^SB[0]^carry and c = majority(SA[0],SB[0],carry).
  - carry<=c.
  - SA, SB shift right by one.
  - s enters the MSB of internal result shift reg SR, which shifts right.
  - counter increments.
  - On the edge where counter == WIDTH-1 (the WIDTH-th RUN edge):
    - sum<=final SR contents, with s in the MSB.
    - cout<=c.
    - go to DONE.
- DONE:
  - done=1, busy=0 for exactly one cycle.
  - Unconditional transition to IDLE on the next edge.
  - start is ignored in DONE.
- Latency: start accepted at edge E0; done is high in the cycle after edge E0+WIDTH. Throughput is one add per WIDTH+2 cycles when start is held high.
- start, a, b and cin are ignored while in RUN/DONE. Operand changes after capture have no effect.
- sum/cout change only on the final RUN edge or on reset. They never show partial results.
- Counter width is clog2(WIDTH) (minimum 1). With WIDTH=1, RUN lasts exactly one edge.
- Arithmetic is modulo 2^WIDTH with overflow reported on cout; {cout,sum} = a+b+cin.
- Reset asserted mid-RUN aborts the operation:
  - No done pulse.
  - Outputs return to zero.
  - After release, the block waits in IDLE for a fresh start.

Test Plan:
- WIDTH=8, a=8'h3C, b=8'h42, cin=0, start pulse -> busy high 8 cycles, then done pulse with sum=8'h7E, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1.
- Hold start=1 continuously with a=8'h01, b=8'h01 -> exactly one done per 10 cycles, each with sum=8'h02; change a to 8'h10 during RUN -> the current result is still 8'h02.
- Start add of 8'h80+8'h80, assert rst after 3 RUN cycles -> busy/done/sum/cout all 0 immediately, no done pulse. Release rst, then start 8'h01+8'h02 -> sum=8'h03.
- WIDTH=1 and WIDTH=2 builds: exhaustive over all a, b, cin against the {cout,sum}=a+b+cin model, checking done timing at E0+WIDTH.

Source files
------------

// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - start/busy/done handshake and operand/result bus of the serial adder
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller driving one full adder for WIDTH cycles
// The result only reaches sum/cout on the last RUN edge, so partial sums are never visible.
module serial_adder_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus_io
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             fa_s, fa_c;
  logic [WIDTH:0]   sr_ext;
  logic             busy, done;

  serial_adder_fa u_fa (
    .a_i (sa_q[0]),
    .b_i (sb_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy    = 1'b0;
    done    = 1'b0;
    // New sum bit enters at the MSB; widened so WIDTH=1 needs no special case.
    sr_ext  = {fa_s, sr_q} >> 1;
    unique case (state_q)
      IDLE: begin
        if (bus_io.start) begin
          sa_d    = bus_io.a;
          sb_d    = bus_io.b;
          carry_d = bus_io.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        carry_d = fa_c;
        sr_d    = sr_ext[WIDTH-1:0];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = sr_ext[WIDTH-1:0];
          cout_d  = fa_c;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_io.busy = busy;
  assign bus_io.done = done;
  assign bus_io.sum  = sum_q;
  assign bus_io.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl at WIDTH 8, 1 and 2
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(8)) if8 ();
  serial_adder_ctrl_if #(.WIDTH(1)) if1 ();
  serial_adder_ctrl_if #(.WIDTH(2)) if2 ();

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus_io(if8));
  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus_io(if1));
  serial_adder_ctrl #(.WIDTH(2)) u_dut2 (.clk(clk), .rst(rst), .bus_io(if2));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Timeline model: ph = edges since the accepted start, 0 when idle.
  int wd[3]      = '{8, 1, 2};
  int ph[3]      = '{0, 0, 0};
  int pend[3]    = '{0, 0, 0};
  int ex_sum[3]  = '{0, 0, 0};
  int ex_cout[3] = '{0, 0, 0};
  int st[3], av[3], bv[3], cv[3];

  always @(posedge clk or posedge rst) begin
    st[0] = int'(if8.start); av[0] = int'(if8.a); bv[0] = int'(if8.b); cv[0] = int'(if8.cin);
    st[1] = int'(if1.start); av[1] = int'(if1.a); bv[1] = int'(if1.b); cv[1] = int'(if1.cin);
    st[2] = int'(if2.start); av[2] = int'(if2.a); bv[2] = int'(if2.b); cv[2] = int'(if2.cin);
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        ph[d] = 0;
        ex_sum[d] = 0;
        ex_cout[d] = 0;
      end else if (ph[d] == 0) begin
        if (st[d] != 0) begin
          ph[d] = 1;
          pend[d] = av[d] + bv[d] + cv[d];
        end
      end else if (ph[d] == wd[d] + 1) begin
        ph[d] = 0;
      end else begin
        ph[d]++;
        if (ph[d] == wd[d] + 1) begin
          ex_sum[d]  = pend[d] % (1 << wd[d]);
          ex_cout[d] = (pend[d] >> wd[d]) & 1;
        end
      end
    end
  end

  logic [8:0] g_busy[3], g_done[3], g_sum[3], g_cout[3];

  always @(negedge clk) begin
    g_busy[0] = {8'b0, if8.busy}; g_done[0] = {8'b0, if8.done};
    g_sum[0]  = {1'b0, if8.sum};  g_cout[0] = {8'b0, if8.cout};
    g_busy[1] = {8'b0, if1.busy}; g_done[1] = {8'b0, if1.done};
    g_sum[1]  = {8'b0, if1.sum};  g_cout[1] = {8'b0, if1.cout};
    g_busy[2] = {8'b0, if2.busy}; g_done[2] = {8'b0, if2.done};
    g_sum[2]  = {7'b0, if2.sum};  g_cout[2] = {8'b0, if2.cout};
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("model_busy_w%0d", wd[d]), g_busy[d], 9'((ph[d] >= 1 && ph[d] <= wd[d]) ? 1 : 0));
      chk($sformatf("model_done_w%0d", wd[d]), g_done[d], 9'((ph[d] == wd[d] + 1) ? 1 : 0));
      chk($sformatf("model_sum_w%0d", wd[d]), g_sum[d], 9'(ex_sum[d]));
      chk($sformatf("model_cout_w%0d", wd[d]), g_cout[d], 9'(ex_cout[d]));
    end
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] es, input logic ec, input string tag);
    int n = 0;
    @(negedge clk);
    if8.a = a; if8.b = b; if8.cin = c; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    chk({tag, "_busy"}, {8'b0, if8.busy}, 9'd1);
    while (!if8.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 9'(n), 9'd8);
    chk({tag, "_sum"}, {1'b0, if8.sum}, {1'b0, es});
    chk({tag, "_cout"}, {8'b0, if8.cout}, {8'b0, ec});
  endtask

  function automatic logic small_done(input int w);
    return (w == 1) ? if1.done : if2.done;
  endfunction

  function automatic int small_res(input int w);
    return (w == 1) ? int'({if1.cout, if1.sum}) : int'({if2.cout, if2.sum});
  endfunction

  task automatic run_small(input int w, input int a, input int b, input int c);
    int n = 0;
    @(negedge clk);
    if (w == 1) begin
      if1.a = 1'(a); if1.b = 1'(b); if1.cin = 1'(c); if1.start = 1'b1;
    end else begin
      if2.a = 2'(a); if2.b = 2'(b); if2.cin = 1'(c); if2.start = 1'b1;
    end
    @(negedge clk);
    if1.start = 1'b0;
    if2.start = 1'b0;
    while (!small_done(w) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("w%0d_latency_%0d_%0d_%0d", w, a, b, c), 9'(n), 9'(w));
    chk($sformatf("w%0d_result_%0d_%0d_%0d", w, a, b, c), 9'(small_res(w)), 9'(a + b + c));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
    if2.start = 1'b0; if2.a = '0; if2.b = '0; if2.cin = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", {8'b0, if8.busy}, 9'd0);
    chk("reset_done", {8'b0, if8.done}, 9'd0);
    chk("reset_sum", {1'b0, if8.sum}, 9'd0);
    chk("reset_cout", {8'b0, if8.cout}, 9'd0);

    run8(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, "add_3c_42");
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
    run8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "add_a5_5a_c1");

    // Start held high: one done per WIDTH+2 cycles, operand change in RUN is ignored.
    ndone = 0;
    @(negedge clk);
    if8.a = 8'h01; if8.b = 8'h01; if8.cin = 1'b0; if8.start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 2) if8.a = 8'h10;
      if (i == 6) if8.a = 8'h01;
      if (if8.done) begin
        ndone++;
        chk("hold_sum", {1'b0, if8.sum}, 9'h002);
        chk("hold_done_cycle", 9'(i % 10), 9'd8);
      end
    end
    if8.start = 1'b0;
    chk("hold_done_count", 9'(ndone), 9'd3);

    // Reset after three RUN edges aborts the add.
    @(negedge clk);
    if8.a = 8'h80; if8.b = 8'h80; if8.cin = 1'b0; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {8'b0, if8.busy}, 9'd0);
    chk("abort_done", {8'b0, if8.done}, 9'd0);
    chk("abort_sum", {1'b0, if8.sum}, 9'd0);
    chk("abort_cout", {8'b0, if8.cout}, 9'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("abort_no_done", {8'b0, if8.done}, 9'd0);
    end
    run8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "add_after_abort");

    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 2; c++)
          run_small(1, a, b, c);
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++)
          run_small(2, a, b, c);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
